// File: rtl/fb_ram_arbiter.sv
// Frame-buffer RAM arbiter: VGA pixel fetch (fixed latency, absolute priority) plus a
// single-entry buffered pixel writer. Optional colour-bar test pattern under FB_TESTPAT_EN.
module fb_ram_arbiter #(
    parameter int unsigned H_ACT  = 320,
    parameter int unsigned V_ACT  = 240,
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
`ifdef FB_TESTPAT_EN
    input  logic              test_mode,
`endif
    input  logic              rd_req,
    input  logic [10:0]       cur_x,
    input  logic [10:0]       cur_y,
    output logic [7:0]        pix_r,
    output logic [7:0]        pix_g,
    output logic [7:0]        pix_b,
    output logic              pix_valid,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [23:0]       wr_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [23:0]       ram_wdata,
    output logic              ram_wren,
    input  logic [23:0]       ram_rdata,
    output logic              wr_oob,
    output logic [15:0]       wr_stall_cnt
);

    localparam int unsigned NPIX  = H_ACT * V_ACT;
    localparam int unsigned DEPTH = RD_LAT + 1;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_READ,
        OP_WRITE
    } op_e;

    op_e               op_sel;
    logic              in_win;
    logic              rd_hit;
    logic [ADDR_W-1:0] rd_addr;
    logic              hold_full;
    logic [ADDR_W-1:0] hold_addr;
    logic [23:0]       hold_data;
    logic              issue_now;
    logic              wr_accept;
    logic              wr_in_range;
    logic [DEPTH-1:0]  tag_valid;
    logic [DEPTH-1:0]  tag_win;
    logic [23:0]       pix_next;

    assign in_win  = (32'(cur_x) < H_ACT) && (32'(cur_y) < V_ACT);
    assign rd_hit  = rd_req & in_win;
    // Modular arithmetic: computing in ADDR_W bits equals full-width then truncation.
    assign rd_addr = ADDR_W'(cur_y) * ADDR_W'(H_ACT) + ADDR_W'(cur_x);

    // One RAM op per clock; an in-window fetch always wins the slot.
    always_comb begin
        op_sel = OP_IDLE;
        if (rd_hit) begin
            op_sel = OP_READ;
        end else if (hold_full) begin
            op_sel = OP_WRITE;
        end
    end

    assign issue_now   = (op_sel == OP_WRITE);
    assign wr_ready    = ~reset & (~hold_full | issue_now);
    assign wr_accept   = wr_valid & wr_ready;
    assign wr_in_range = (32'(wr_addr) < NPIX);

    always_ff @(posedge clock) begin
        if (reset) begin
            ram_addr     <= '0;
            ram_wdata    <= '0;
            ram_wren     <= 1'b0;
            hold_full    <= 1'b0;
            hold_addr    <= '0;
            hold_data    <= '0;
            wr_oob       <= 1'b0;
            wr_stall_cnt <= '0;
        end else begin
            ram_wren <= 1'b0;
            case (op_sel)
                OP_READ: begin
                    ram_addr <= rd_addr;
                end
                OP_WRITE: begin
                    ram_addr  <= hold_addr;
                    ram_wdata <= hold_data;
                    ram_wren  <= 1'b1;
                end
                default: begin
                end
            endcase

            // Issue and refill can happen on the same edge; the refill wins.
            if (issue_now) begin
                hold_full <= 1'b0;
            end
            if (wr_accept && wr_in_range) begin
                hold_full <= 1'b1;
                hold_addr <= wr_addr;
                hold_data <= wr_data;
            end
            if (wr_accept && !wr_in_range) begin
                wr_oob <= 1'b1;
            end

            if (hold_full && rd_hit && (wr_stall_cnt != 16'hFFFF)) begin
                wr_stall_cnt <= wr_stall_cnt + 16'd1;
            end
        end
    end

`ifdef FB_TESTPAT_EN
    logic [DEPTH-1:0] tag_tp;
    logic [23:0]      tag_col [DEPTH];
    logic [2:0]       bar_idx;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    assign bar_idx = 3'({cur_x, 3'b000} / 14'(H_ACT));

    // Bar colour rides alongside the fetch tag so pattern latency matches RAM latency.
    always_ff @(posedge clock) begin
        tag_tp[0]  <= test_mode;
        tag_col[0] <= bar_colour(bar_idx);
        for (int i = 1; i < int'(DEPTH); i++) begin
            tag_tp[i]  <= tag_tp[i-1];
            tag_col[i] <= tag_col[i-1];
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_valid <= '0;
            tag_win   <= '0;
        end else begin
            tag_valid[0] <= rd_req;
            tag_win[0]   <= in_win;
            for (int i = 1; i < int'(DEPTH); i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_win[i]   <= tag_win[i-1];
            end
        end
    end

    always_comb begin
        pix_next = 24'h000000;
        if (tag_win[RD_LAT]) begin
`ifdef FB_TESTPAT_EN
            pix_next = tag_tp[RD_LAT] ? tag_col[RD_LAT] : ram_rdata;
`else
            pix_next = ram_rdata;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pix_r     <= 8'h00;
            pix_g     <= 8'h00;
            pix_b     <= 8'h00;
            pix_valid <= 1'b0;
        end else begin
            pix_valid <= tag_valid[RD_LAT];
            if (tag_valid[RD_LAT]) begin
                pix_r <= pix_next[23:16];
                pix_g <= pix_next[15:8];
                pix_b <= pix_next[7:0];
            end
        end
    end

endmodule

// File: tb/tb_fb_ram_arbiter.sv
// Directed bench for fb_ram_arbiter with a 1-clock synchronous RAM model behind it.
module tb_fb_ram_arbiter;

    logic        clock;
    logic        reset;
    logic        rd_req;
    logic [10:0] cur_x;
    logic [10:0] cur_y;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        pix_valid;
    logic        wr_valid;
    logic        wr_ready;
    logic [16:0] wr_addr;
    logic [23:0] wr_data;
    logic [16:0] ram_addr;
    logic [23:0] ram_wdata;
    logic        ram_wren;
    logic [23:0] ram_rdata;
    logic        wr_oob;
    logic [15:0] wr_stall_cnt;

    int checks;
    int failures;

    logic [23:0] mem [0:131071];

    fb_ram_arbiter dut (
        .clock        (clock),
        .reset        (reset),
`ifdef FB_TESTPAT_EN
        .test_mode    (1'b0),
`endif
        .rd_req       (rd_req),
        .cur_x        (cur_x),
        .cur_y        (cur_y),
        .pix_r        (pix_r),
        .pix_g        (pix_g),
        .pix_b        (pix_b),
        .pix_valid    (pix_valid),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_wren     (ram_wren),
        .ram_rdata    (ram_rdata),
        .wr_oob       (wr_oob),
        .wr_stall_cnt (wr_stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM: address registered at the edge, q valid the following cycle.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Fetch one pixel and follow it to its pix_valid strobe three clocks later.
    task automatic fetch(input string tag, input logic [10:0] x, input logic [10:0] y,
                         input logic [16:0] exp_addr, input logic [23:0] exp_rgb);
        rd_req = 1'b1;
        cur_x  = x;
        cur_y  = y;
        tick();
        check({tag, "_addr"}, 32'(ram_addr), 32'(exp_addr));
        check({tag, "_wren"}, 32'(ram_wren), 32'd0);
        rd_req = 1'b0;
        tick();
        check({tag, "_pv1"}, 32'(pix_valid), 32'd0);
        tick();
        check({tag, "_pv2"}, 32'(pix_valid), 32'd1);
        check({tag, "_rgb"}, {8'h00, pix_r, pix_g, pix_b}, {8'h00, exp_rgb});
        tick();
        check({tag, "_pv3"}, 32'(pix_valid), 32'd0);
        check({tag, "_hold"}, {8'h00, pix_r, pix_g, pix_b}, {8'h00, exp_rgb});
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 131072; i++) mem[i] = 24'h000000;
        mem[0]     = 24'h123456;
        mem[76799] = 24'hABCDEF;
        mem[645]   = 24'h0A0B0C;
        mem[10]    = 24'h445566;
        mem[11]    = 24'h778899;
        ram_rdata  = 24'h000000;

        reset    = 1'b1;
        rd_req   = 1'b0;
        cur_x    = '0;
        cur_y    = '0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        tick();
        tick();
        tick();
        check("rst_pix", {8'h00, pix_r, pix_g, pix_b}, 32'd0);
        check("rst_pv", 32'(pix_valid), 32'd0);
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_wdata", 32'(ram_wdata), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        check("rst_oob", 32'(wr_oob), 32'd0);
        check("rst_stall", 32'(wr_stall_cnt), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd0);

        reset = 1'b0;
        #1;
        check("ready_idle", 32'(wr_ready), 32'd1);

        fetch("rd_00", 11'd0, 11'd0, 17'd0, 24'h123456);
        fetch("rd_last", 11'd319, 11'd239, 17'd76799, 24'hABCDEF);
        fetch("rd_xoob", 11'd320, 11'd0, 17'd76799, 24'h000000);
        fetch("rd_yoob", 11'd0, 11'd240, 17'd76799, 24'h000000);
        fetch("rd_mid", 11'd5, 11'd2, 17'd645, 24'h0A0B0C);

        // Two writes back to back: second one refills while the first issues.
        wr_valid = 1'b1;
        wr_addr  = 17'd100;
        wr_data  = 24'hAABBCC;
        #1;
        check("wr1_ready", 32'(wr_ready), 32'd1);
        tick();
        check("wr1_wren0", 32'(ram_wren), 32'd0);
        wr_addr = 17'd101;
        wr_data = 24'h010203;
        #1;
        check("wr2_ready", 32'(wr_ready), 32'd1);
        tick();
        check("wr1_wren", 32'(ram_wren), 32'd1);
        check("wr1_addr", 32'(ram_addr), 32'd100);
        check("wr1_data", 32'(ram_wdata), 32'hAABBCC);
        wr_valid = 1'b0;
        tick();
        check("wr2_wren", 32'(ram_wren), 32'd1);
        check("wr2_addr", 32'(ram_addr), 32'd101);
        check("wr2_data", 32'(ram_wdata), 32'h010203);
        tick();
        check("wr_idle_wren", 32'(ram_wren), 32'd0);
        check("wr_idle_addr", 32'(ram_addr), 32'd101);
        fetch("rd_w100", 11'd100, 11'd0, 17'd100, 24'hAABBCC);
        fetch("rd_w101", 11'd101, 11'd0, 17'd101, 24'h010203);

        // Held write blocked by an in-window read, issued in the gap.
        wr_valid = 1'b1;
        wr_addr  = 17'd200;
        wr_data  = 24'h112233;
        tick();
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        cur_x    = 11'd10;
        cur_y    = 11'd0;
        #1;
        check("st_ready", 32'(wr_ready), 32'd0);
        tick();
        check("st_raddr", 32'(ram_addr), 32'd10);
        check("st_rwren", 32'(ram_wren), 32'd0);
        check("st_cnt", 32'(wr_stall_cnt), 32'd1);
        rd_req = 1'b0;
        tick();
        check("st_wwren", 32'(ram_wren), 32'd1);
        check("st_waddr", 32'(ram_addr), 32'd200);
        check("st_wdata", 32'(ram_wdata), 32'h112233);
        check("st_pv0", 32'(pix_valid), 32'd0);
        rd_req = 1'b1;
        cur_x  = 11'd11;
        tick();
        check("st_pv1", 32'(pix_valid), 32'd1);
        check("st_rgb1", {8'h00, pix_r, pix_g, pix_b}, 32'h445566);
        check("st_raddr2", 32'(ram_addr), 32'd11);
        check("st_cnt2", 32'(wr_stall_cnt), 32'd1);
        rd_req = 1'b0;
        tick();
        check("st_pv2", 32'(pix_valid), 32'd0);
        tick();
        check("st_pv3", 32'(pix_valid), 32'd1);
        check("st_rgb2", {8'h00, pix_r, pix_g, pix_b}, 32'h778899);
        check("st_mem", 32'(mem[200]), 32'h112233);

        // Out-of-range write: accepted, dropped, sticky flag.
        wr_valid = 1'b1;
        wr_addr  = 17'd76800;
        wr_data  = 24'hFFFFFF;
        #1;
        check("oob_ready", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("oob_flag", 32'(wr_oob), 32'd1);
            check("oob_wren", 32'(ram_wren), 32'd0);
            tick();
        end
        check("oob_addr", 32'(ram_addr), 32'd11);

        // Reset one clock after an in-window fetch: the fetch must vanish.
        rd_req = 1'b1;
        cur_x  = 11'd5;
        cur_y  = 11'd2;
        tick();
        check("rr_addr", 32'(ram_addr), 32'd645);
        rd_req = 1'b0;
        reset  = 1'b1;
        #1;
        check("rr_ready", 32'(wr_ready), 32'd0);
        tick();
        reset = 1'b0;
        check("rr_pix", {8'h00, pix_r, pix_g, pix_b}, 32'd0);
        check("rr_addr0", 32'(ram_addr), 32'd0);
        check("rr_wren", 32'(ram_wren), 32'd0);
        check("rr_oob", 32'(wr_oob), 32'd0);
        check("rr_stall", 32'(wr_stall_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("rr_pv", 32'(pix_valid), 32'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_ram_arbiter.md
Name: fb_ram_arbiter

Overview:
- Owns the single-port 24-bit frame-buffer RAM (H_ACT x V_ACT words, one word per pixel).
- Shares the RAM between two requesters:
  - the VGA pixel fetch path, which has absolute priority and fixed latency;
  - a pixel writer (image loader / drawing engine) with a valid/ready handshake.
- Performs X/Y-to-address translation and active-window blanking, and presents registered RGB to the VGA controller.
- Sits between the VGA controller, the frame-buffer RAM and the write source, all on the RAM clock domain.

Parameters:
- H_ACT, 320, active window width in pixels.
- V_ACT, 240, active window height in pixels.
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= H_ACT*V_ACT.
- RD_LAT, 1, RAM read latency in clocks, from address registered at RAM input to q valid.

Ports:
- clock  in  1  RAM/arbiter clock (100 MHz in the current build)
- reset  in  1  synchronous, active-high reset
- rd_req  in  1  pixel fetch request from the VGA controller; at most one per 2 clocks
- cur_x  in  11  current pixel X, sampled with rd_req
- cur_y  in  11  current pixel Y, sampled with rd_req
- pix_r  out  8  red output
- pix_g  out  8  green output
- pix_b  out  8  blue output
- pix_valid  out  1  one-clock strobe marking that pix_r/g/b are updated
- wr_valid  in  1  write request valid
- wr_ready  out  1  write request accepted when wr_valid & wr_ready
- wr_addr  in  ADDR_W  linear pixel address for the write
- wr_data  in  24  {R[23:16], G[15:8], B[7:0]}
- ram_addr  out  ADDR_W  to RAM address
- ram_wdata  out  24  to RAM data
- ram_wren  out  1  to RAM write enable
- ram_rdata  in  24  RAM q
- wr_oob  out  1  sticky flag: an out-of-range write was dropped
- wr_stall_cnt  out  16  saturating count of cycles a held write was blocked by a read

Behaviour:
- **Reset** (synchronous, while reset=1):
  - pix_r/g/b = 0, pix_valid = 0, ram_addr = 0, ram_wdata = 0, ram_wren = 0;
  - write hold register empty; wr_oob = 0; wr_stall_cnt = 0;
  - wr_ready = 0 while reset is high;
  - all pipeline valid bits are cleared. An in-flight fetch is discarded and produces no pix_valid.
- **Window check:** in_win = (cur_x < H_ACT) && (cur_y < V_ACT), computed in the rd_req cycle.
- **Address:** cur_y*H_ACT + cur_x, computed at full width and truncated to ADDR_W.
- **Arbitration** (registered RAM-side outputs, one op per clock):
  - Cycle with rd_req=1 and in_win: next-edge ram_addr = computed address, ram_wren = 0 (READ).
  - Cycle with rd_req=1 and !in_win: the RAM is not read and the slot is free for a write. The fetch still produces pix_valid with black output.
  - Otherwise, if the hold register is full: next-edge ram_addr = held addr, ram_wdata = held data, ram_wren = 1; the hold register empties (WRITE).
  - Otherwise ram_wren = 0 and ram_addr holds its previous value (IDLE).
- **Write hold register** (1 entry):
  - wr_ready = !full | issue_now, where issue_now = full & !(rd_req & in_win). This path is combinational; a simultaneous issue and accept refills the register in the same edge.
  - Accept with wr_addr >= H_ACT*V_ACT: the write is accepted but not stored, and wr_oob is set. wr_oob clears only on reset.
- **Stall counter:** wr_stall_cnt increments when full & rd_req & in_win; it saturates at 0xFFFF.
- **Read pipeline:**
  - An (in_win, valid) tag shift register of depth RD_LAT+1 tracks each fetch.
  - pix_valid is asserted exactly RD_LAT+2 clocks after the rd_req cycle.
  - pix_* = ram_rdata slices if the tag's in_win=1, else 0.
  - pix_* hold their value between strobes.
- **rd_req spacing:** back-to-back rd_req (spacing < 2) is illegal; behaviour is undefined.
- **Writer throughput:** the writer always gets every slot not used by an in-window read, so it is never starved for more than one clock per pixel.

Optional Feature:
- Macro: FB_TESTPAT_EN.
- **Defined:** adds input port test_mode (1 bit).
  - When test_mode=1, in-window pixels output 8 vertical colour bars instead of RAM data. Bar index = (cur_x * 8) / H_ACT; bars in order white, yellow, cyan, green, magenta, red, blue, black, each full-scale 0xFF/0x00 per channel.
  - Bar colour is tagged in the pipeline so latency is unchanged.
  - RAM reads are still issued.
- **Undefined:** port absent; output is always RAM data.

Test Plan:
- Reset release, then rd_req at x=0, y=0 with ram_rdata=0x123456 -> ram_addr=0, ram_wren=0; pix_valid at +3 clocks (RD_LAT=1) with r=0x12, g=0x34, b=0x56.
- rd_req at x=319, y=239 -> ram_addr=76799. rd_req at x=320, y=0 -> no RAM read; pix_valid at +3 with RGB=0.
- wr_valid with addr=100, data=0xAABBCC and no reads -> wr_ready=1; one clock later ram_wren=1, ram_addr=100, ram_wdata=0xAABBCC.
- Write held while rd_req in-window every 2 clocks -> the write issues on the first non-read clock; wr_stall_cnt=1; read data and latency unaffected.
- Write with wr_addr=76800 -> accepted, ram_wren never asserted, wr_oob=1 until reset.
- Reset asserted one clock after an in-window rd_req -> no pix_valid afterwards; all outputs 0; wr_stall_cnt=0.
